jtag_dtm_tap: RTL and testbench
===============================

Name: jtag_dtm_tap

Overview:
- JTAG Debug Transport Module: IEEE 1149.1 TAP controller plus IR/DR registers (IDCODE, DTMCS, DMI, BYPASS), implemented fully in the clk domain by oversampling TCK.
- Sits directly upstream of the debug module.
- Converts DMI scans into 4-phase request/ack transfers toward the DM and collects DM responses for the next DMI capture.

Parameters:
- DMI_ADDR_BITS, 6, DMI address field width.
- DMI_DATA_BITS, 32, DMI data field width.
- DMI_OP_BITS, 2, DMI op/status field width.
- IDCODE_VAL, 32'h1E200A6D, value returned by IDCODE.
- SYNC_STAGES, 2, synchronizer depth for TCK/TMS/TDI (minimum 2).

Ports:
- clk  in  1  system clock; frequency ≥ 8× TCK.
- rst_n  in  1  reset, asynchronous, active-low.
- jtag_tck_i  in  1  JTAG TCK, asynchronous.
- jtag_tms_i  in  1  JTAG TMS, asynchronous.
- jtag_tdi_i  in  1  JTAG TDI, asynchronous.
- jtag_tdo_o  out  1  JTAG TDO.
- dtm_req_valid_o  out  1  request to DM, held until ack.
- dtm_req_data_o  out  A+D+O  {addr, data, op}.
- dm_ack_i  in  1  DM acknowledges request.
- dm_resp_valid_i  in  1  DM response valid.
- dm_resp_data_i  in  A+D+O  {addr, rdata, status}.
- dtm_ack_o  out  1  acknowledge to DM response.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs are 0 during reset (including dtm_req_data_o). TAP state = Test-Logic-Reset, IR = 5'h01, busy = 0, sticky error = 0, response register = 0.
- Synchronization: TCK, TMS and TDI each pass through SYNC_STAGES flops. tck_rise = synchronized TCK high while the previous sample was low; tck_fall is the mirror.
- Pin-to-action latency: SYNC_STAGES+1 clk.
- TAP state machine: standard 16 states, advanced only on tck_rise using synchronized TMS. Five consecutive TMS=1 rises reach TLR from any state.
- On tck_rise, actions use the state before the transition:
  - Capture-IR: IR shift register loads 5'b00001.
  - Shift-IR: shift right; TDI enters the MSB.
  - Update-IR: IR takes the shift value.
  - TLR: IR = 5'h01.
- Instruction decode:
  - 01 = IDCODE (32 bits).
  - 10 = DTMCS (32 bits).
  - 11 = DMI (A+D+O bits).
  - Every other code = BYPASS (1 bit, captures 0).
- Capture-DR loads the selected register:
  - IDCODE: IDCODE_VAL.
  - DTMCS: {14'b0, 2'b0, 1'b0, idle=3'd5, dmistat[1:0], abits=DMI_ADDR_BITS[5:0], version=4'd1}.
  - DMI: {last_addr, resp_data, status}. status = 2'b11 if sticky error, else 2'b00.
- Shift-DR: right shift through the active length; TDI enters the MSB of that length.
- TDO: on tck_fall, jtag_tdo_o = shift register LSB when in Shift-IR or Shift-DR; otherwise 0.
- Update-DR, DTMCS: bit16 (dmireset) clears the sticky error. Bit17 (dmihardreset) clears the sticky error and busy, and drops any request that has not yet been acked.
- Update-DR, DMI:
  - If busy: set the sticky error; no request issued.
  - Else if the sticky error is set: ignore the scan.
  - Else if op ∈ {1,2}: latch {addr, data, op} onto dtm_req_data_o, raise dtm_req_valid_o and set busy. last_addr = addr.
  - op = 0 or 3: no request.
- Request handshake:
  - valid is held with stable data until dm_ack_i = 1, then valid drops the next clk.
  - No new valid until dm_ack_i has returned to 0.
- Response handshake:
  - On dm_resp_valid_i = 1 with dtm_ack_o = 0: capture resp data [D+O-1:O] into resp_data, raise dtm_ack_o.
  - Keep dtm_ack_o high until dm_resp_valid_i = 0, then drop it and clear busy.
- Busy spans from Update-DR issue to the response ack falling.
- A simultaneous dmihardreset and response arrival: hardreset wins; the response is still acked but discarded.
- TLR does not affect busy, handshakes, sticky error or resp_data.
- rst_n asserted mid-transfer: everything returns to reset values immediately.

Optional Feature:
- Macro: JTAG_DTM_BUSY_ERR_EN.
- Defined: sticky busy error as described; dmistat = 2'b11 while set; DMI status field = 2'b11.
- Undefined: the sticky error logic is removed. An Update-DR while busy is silently dropped, dmistat always reads 0, the DMI status field always reads 2'b00, and dmireset is a no-op.

Test Plan:
- IDCODE after reset: reset, then TLR→Shift-DR, shift 32 bits of TDI=0 → TDO sequence LSB-first = 0x1E200A6D, no dtm_req_valid_o.
- DTMCS read: IR=5'h10, shift 32 bits → 0x00005061.
- DMI write: IR=5'h11, scan {6'h10, 32'h80000001, 2'b10} → after Update-DR:
  - dtm_req_valid_o = 1 with that data;
  - with dm_ack_i 1 clk later, valid drops the next clk;
  - a response with data 0x0 → dtm_ack_o pulses through valid low, busy clears.
- DMI read: scan {6'h11, 0, 2'b01}; DM responds with data 0x00430C82. Next DMI scan captures {6'h11, 32'h00430C82, 2'b00} on TDO.
- Busy error (macro on):
  - Issue a read and hold dm_ack_i = 0; a second DMI scan → no second request and the next capture status = 2'b11, DTMCS dmistat = 3.
  - DTMCS write 0x00010000 → dmistat = 0.
- Robustness:
  - TMS=1 for 5 TCK mid-Shift-DR → TLR, IR = 01, pending handshake unaffected.
  - rst_n low mid-request → valid/ack = 0 immediately.

Source files
------------

// File: rtl/jtag_dtm_tap.sv
// JTAG debug transport module: oversampled TAP, IR/DR chain and DMI request/response handshakes.
// Optional macro JTAG_DTM_BUSY_ERR_EN enables the sticky busy-error (dmistat/status = 2'b11).
module jtag_dtm_tap #(
  parameter int unsigned DMI_ADDR_BITS = 6,
  parameter int unsigned DMI_DATA_BITS = 32,
  parameter int unsigned DMI_OP_BITS   = 2,
  parameter logic [31:0] IDCODE_VAL    = 32'h1E200A6D,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic jtag_tck_i,
  input  logic jtag_tms_i,
  input  logic jtag_tdi_i,
  output logic jtag_tdo_o,
  output logic dtm_req_valid_o,
  output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data_o,
  input  logic dm_ack_i,
  input  logic dm_resp_valid_i,
  input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data_i,
  output logic dtm_ack_o
);

  localparam int unsigned A     = DMI_ADDR_BITS;
  localparam int unsigned D     = DMI_DATA_BITS;
  localparam int unsigned O     = DMI_OP_BITS;
  localparam int unsigned DMI_W = A + D + O;
  localparam int unsigned DR_W  = (DMI_W > 32) ? DMI_W : 32;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_e;

  logic [SYNC_STAGES-1:0] r_tck_s;
  logic [SYNC_STAGES-1:0] r_tms_s;
  logic [SYNC_STAGES-1:0] r_tdi_s;
  logic                   r_tck_q;
  logic w_tck, w_tms, w_tdi, w_rise, w_fall;

  tap_e r_state, w_next;
  logic w_in_tlr, w_cap_dr, w_sh_dr, w_upd_dr;
  logic w_cap_ir, w_sh_ir, w_upd_ir;

  logic [4:0]      r_ir, r_ir_sr;
  logic [DR_W-1:0] r_dr_sr, w_cap_val, w_shift_val;
  logic            r_tdo;
  logic w_sel_idc, w_sel_dtm, w_sel_dmi, w_sel_byp;

  logic [A-1:0]     r_last_addr;
  logic [D-1:0]     r_resp_data;
  logic             r_busy, r_req_valid, r_req_pend, r_ack;
  logic [DMI_W-1:0] r_req_data;

  logic         w_err;
  logic [1:0]   w_dmistat;
  logic [O-1:0] w_status;
  logic [31:0]  w_dtmcs;
  logic [O-1:0] w_op;
  logic [D-1:0] w_data;
  logic [A-1:0] w_addr;
  logic w_upd_dmi, w_upd_dtm, w_hard, w_op_ok, w_issue;
  logic [A+O-1:0] w_unused_resp;

  // Oversample the JTAG pins and detect TCK edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tck_s <= '0;
      r_tms_s <= '0;
      r_tdi_s <= '0;
      r_tck_q <= 1'b0;
    end else begin
      r_tck_s <= {r_tck_s[SYNC_STAGES-2:0], jtag_tck_i};
      r_tms_s <= {r_tms_s[SYNC_STAGES-2:0], jtag_tms_i};
      r_tdi_s <= {r_tdi_s[SYNC_STAGES-2:0], jtag_tdi_i};
      r_tck_q <= r_tck_s[SYNC_STAGES-1];
    end
  end

  assign w_tck  = r_tck_s[SYNC_STAGES-1];
  assign w_tms  = r_tms_s[SYNC_STAGES-1];
  assign w_tdi  = r_tdi_s[SYNC_STAGES-1];
  assign w_rise = w_tck & ~r_tck_q;
  assign w_fall = ~w_tck & r_tck_q;

  // TAP state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= TLR;
    else        r_state <= w_next;
  end

  // TAP next state, evaluated only on a TCK rise
  always_comb begin
    w_next = r_state;
    if (w_rise) begin
      unique case (r_state)
        TLR:    w_next = w_tms ? TLR    : RTI;
        RTI:    w_next = w_tms ? SEL_DR : RTI;
        SEL_DR: w_next = w_tms ? SEL_IR : CAP_DR;
        CAP_DR: w_next = w_tms ? EX1_DR : SH_DR;
        SH_DR:  w_next = w_tms ? EX1_DR : SH_DR;
        EX1_DR: w_next = w_tms ? UPD_DR : PA_DR;
        PA_DR:  w_next = w_tms ? EX2_DR : PA_DR;
        EX2_DR: w_next = w_tms ? UPD_DR : SH_DR;
        UPD_DR: w_next = w_tms ? SEL_DR : RTI;
        SEL_IR: w_next = w_tms ? TLR    : CAP_IR;
        CAP_IR: w_next = w_tms ? EX1_IR : SH_IR;
        SH_IR:  w_next = w_tms ? EX1_IR : SH_IR;
        EX1_IR: w_next = w_tms ? UPD_IR : PA_IR;
        PA_IR:  w_next = w_tms ? EX2_IR : PA_IR;
        EX2_IR: w_next = w_tms ? UPD_IR : SH_IR;
        UPD_IR: w_next = w_tms ? SEL_DR : RTI;
      endcase
    end
  end

  // Decode the current state into register actions
  always_comb begin
    w_in_tlr = 1'b0;
    w_cap_dr = 1'b0;
    w_sh_dr  = 1'b0;
    w_upd_dr = 1'b0;
    w_cap_ir = 1'b0;
    w_sh_ir  = 1'b0;
    w_upd_ir = 1'b0;
    unique case (r_state)
      TLR:     w_in_tlr = 1'b1;
      CAP_DR:  w_cap_dr = 1'b1;
      SH_DR:   w_sh_dr  = 1'b1;
      UPD_DR:  w_upd_dr = 1'b1;
      CAP_IR:  w_cap_ir = 1'b1;
      SH_IR:   w_sh_ir  = 1'b1;
      UPD_IR:  w_upd_ir = 1'b1;
      default: ;
    endcase
  end

  // Instruction register and its shift stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir    <= 5'h01;
      r_ir_sr <= '0;
    end else if (w_rise) begin
      if (w_in_tlr) r_ir    <= 5'h01;
      if (w_cap_ir) r_ir_sr <= 5'b00001;
      if (w_sh_ir)  r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
      if (w_upd_ir) r_ir    <= r_ir_sr;
    end
  end

  assign w_sel_idc = (r_ir == 5'h01);
  assign w_sel_dtm = (r_ir == 5'h10);
  assign w_sel_dmi = (r_ir == 5'h11);
  assign w_sel_byp = ~(w_sel_idc | w_sel_dtm | w_sel_dmi);

  assign w_dmistat = {2{w_err}};
  assign w_status  = {O{w_err}};
  assign w_dtmcs   = {14'b0, 2'b0, 1'b0, 3'd5, w_dmistat,
                      6'(DMI_ADDR_BITS), 4'd1};

  // Capture value and shifted value for the selected data register
  always_comb begin
    w_cap_val   = '0;
    w_shift_val = r_dr_sr;
    unique case (1'b1)
      w_sel_idc: begin
        w_cap_val[31:0]   = IDCODE_VAL;
        w_shift_val[31:0] = {w_tdi, r_dr_sr[31:1]};
      end
      w_sel_dtm: begin
        w_cap_val[31:0]   = w_dtmcs;
        w_shift_val[31:0] = {w_tdi, r_dr_sr[31:1]};
      end
      w_sel_dmi: begin
        w_cap_val[DMI_W-1:0]   = {r_last_addr, r_resp_data, w_status};
        w_shift_val[DMI_W-1:0] = {w_tdi, r_dr_sr[DMI_W-1:1]};
      end
      w_sel_byp: begin
        w_cap_val[0]   = 1'b0;
        w_shift_val[0] = w_tdi;
      end
    endcase
  end

  // Data register capture and shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dr_sr <= '0;
    end else if (w_rise) begin
      if (w_cap_dr)     r_dr_sr <= w_cap_val;
      else if (w_sh_dr) r_dr_sr <= w_shift_val;
    end
  end

  // TDO changes on TCK fall from whichever chain is shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tdo <= 1'b0;
    else if (w_fall) r_tdo <= w_sh_ir ? r_ir_sr[0] :
                              w_sh_dr ? r_dr_sr[0] : 1'b0;
  end

  assign w_op      = r_dr_sr[O-1:0];
  assign w_data    = r_dr_sr[D+O-1:O];
  assign w_addr    = r_dr_sr[DMI_W-1:D+O];
  assign w_upd_dmi = w_rise & w_upd_dr & w_sel_dmi;
  assign w_upd_dtm = w_rise & w_upd_dr & w_sel_dtm;
  assign w_hard    = w_upd_dtm & r_dr_sr[17];
  assign w_op_ok   = (w_op == O'(1)) | (w_op == O'(2));
  assign w_issue   = w_upd_dmi & ~r_busy & ~w_err & w_op_ok;

`ifdef JTAG_DTM_BUSY_ERR_EN
  logic r_err;
  logic w_dmirst;
  assign w_dmirst = w_upd_dtm & r_dr_sr[16];

  // Sticky error: set by a DMI update while busy, cleared via DTMCS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_err <= 1'b0;
    else if (w_hard | w_dmirst)  r_err <= 1'b0;
    else if (w_upd_dmi & r_busy) r_err <= 1'b1;
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  // Request issue, DM request/response handshakes and busy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_pend  <= 1'b0;
      r_req_data  <= '0;
      r_ack       <= 1'b0;
      r_resp_data <= '0;
      r_last_addr <= '0;
    end else begin
      if (r_req_valid & dm_ack_i) r_req_valid <= 1'b0;
      if (r_req_pend & ~dm_ack_i) begin
        r_req_valid <= 1'b1;
        r_req_pend  <= 1'b0;
      end
      if (dm_resp_valid_i & ~r_ack) begin
        r_ack <= 1'b1;
        if (!w_hard) r_resp_data <= dm_resp_data_i[D+O-1:O];
      end else if (r_ack & ~dm_resp_valid_i) begin
        r_ack  <= 1'b0;
        r_busy <= 1'b0;
      end
      if (w_issue) begin
        r_req_data  <= {w_addr, w_data, w_op};
        r_last_addr <= w_addr;
        r_busy      <= 1'b1;
        if (dm_ack_i) r_req_pend  <= 1'b1;
        else          r_req_valid <= 1'b1;
      end
      if (w_hard) begin
        r_busy      <= 1'b0;
        r_req_valid <= 1'b0;
        r_req_pend  <= 1'b0;
      end
    end
  end

  assign w_unused_resp = {dm_resp_data_i[DMI_W-1:D+O], dm_resp_data_i[O-1:0]};

  assign jtag_tdo_o      = r_tdo;
  assign dtm_req_valid_o = r_req_valid;
  assign dtm_req_data_o  = r_req_data;
  assign dtm_ack_o       = r_ack;

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Directed bench for jtag_dtm_tap: bit-banged TCK, scoreboard of expected
// captures and DM requests, immediate assertions at each comparison.
module tb_jtag_dtm_tap;

  localparam time TH = 100ns;

`ifdef JTAG_DTM_BUSY_ERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tck = 1'b0;
  logic        tms = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic        req_valid;
  logic [39:0] req_data;
  logic        dm_ack = 1'b0;
  logic        resp_valid = 1'b0;
  logic [39:0] resp_data = '0;
  logic        dtm_ack;

  int n_run  = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  string       tag_q[$];

  logic [31:0] m_resp;
  logic [5:0]  m_last;
  logic [39:0] dout;
  logic [4:0]  irc;
  logic        t;

  jtag_dtm_tap dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .jtag_tck_i      (tck),
    .jtag_tms_i      (tms),
    .jtag_tdi_i      (tdi),
    .jtag_tdo_o      (tdo),
    .dtm_req_valid_o (req_valid),
    .dtm_req_data_o  (req_data),
    .dm_ack_i        (dm_ack),
    .dm_resp_valid_i (resp_valid),
    .dm_resp_data_i  (resp_data),
    .dtm_ack_o       (dtm_ack)
  );

  always #5ns clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [63:0] dmi(input logic [5:0] a,
                                      input logic [31:0] d,
                                      input logic [1:0] op);
    return {24'b0, a, d, op};
  endfunction

  task automatic tck_cycle(input logic m, input logic di, output logic dq);
    tck = 1'b0;
    tms = m;
    tdi = di;
    #(TH);
    dq  = tdo;
    tck = 1'b1;
    #(TH);
  endtask

  task automatic scan_ir(input logic [4:0] ir, output logic [4:0] cap);
    logic q;
    tck_cycle(1'b1, 1'b0, q);
    tck_cycle(1'b1, 1'b0, q);
    tck_cycle(1'b0, 1'b0, q);
    tck_cycle(1'b0, 1'b0, q);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, ir[i], q);
      cap[i] = q;
    end
    tck_cycle(1'b1, 1'b0, q);
    tck_cycle(1'b0, 1'b0, q);
  endtask

  task automatic scan_dr(input logic [39:0] din, input int len,
                         output logic [39:0] dq);
    logic q;
    dq = '0;
    tck_cycle(1'b1, 1'b0, q);
    tck_cycle(1'b0, 1'b0, q);
    tck_cycle(1'b0, 1'b0, q);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], q);
      dq[i] = q;
    end
    tck_cycle(1'b1, 1'b0, q);
    tck_cycle(1'b0, 1'b0, q);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50 && !req_valid; i++) @(negedge clk);
    check("req_valid_seen", 64'(req_valid), 64'd1);
    pop_check(64'(req_data));
  endtask

  task automatic dm_complete(input logic [5:0] a, input logic [31:0] rd);
    @(negedge clk);
    dm_ack = 1'b1;
    @(negedge clk);
    check("req_valid_drop", 64'(req_valid), 64'd0);
    dm_ack = 1'b0;
    @(negedge clk);
    resp_valid = 1'b1;
    resp_data  = {a, rd, 2'b00};
    @(negedge clk);
    check("resp_ack_rise", 64'(dtm_ack), 64'd1);
    @(negedge clk);
    check("resp_ack_hold", 64'(dtm_ack), 64'd1);
    resp_valid = 1'b0;
    @(negedge clk);
    check("resp_ack_fall", 64'(dtm_ack), 64'd0);
  endtask

  initial begin
    // reset state
    #23ns;
    check("reset_outputs", 64'({req_valid, req_data, dtm_ack, tdo}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // IDCODE after reset
    tck_cycle(1'b0, 1'b0, t);
    push("idcode", 64'h1E200A6D);
    scan_dr('0, 32, dout);
    pop_check(64'(dout));
    check("no_req_after_idcode", 64'(req_valid), 64'd0);

    // DTMCS read
    push("ir_capture", 64'h01);
    scan_ir(5'h10, irc);
    pop_check(64'(irc));
    push("dtmcs_read", 64'h00005061);
    scan_dr('0, 32, dout);
    pop_check(64'(dout));

    // DMI write
    scan_ir(5'h11, irc);
    push("dmi_cap_reset", dmi(6'h00, 32'h0, 2'b00));
    push("dmi_write_req", dmi(6'h10, 32'h80000001, 2'b10));
    scan_dr(40'(dmi(6'h10, 32'h80000001, 2'b10)), 40, dout);
    pop_check(64'(dout));
    wait_req();
    dm_complete(6'h10, 32'h0);
    m_last = 6'h10;
    m_resp = 32'h0;

    // DMI read then readback capture
    push("dmi_cap_after_write", dmi(m_last, m_resp, 2'b00));
    push("dmi_read_req", dmi(6'h11, 32'h0, 2'b01));
    scan_dr(40'(dmi(6'h11, 32'h0, 2'b01)), 40, dout);
    pop_check(64'(dout));
    wait_req();
    dm_complete(6'h11, 32'h00430C82);
    m_last = 6'h11;
    m_resp = 32'h00430C82;
    push("dmi_read_result", dmi(6'h11, 32'h00430C82, 2'b00));
    scan_dr('0, 40, dout);
    pop_check(64'(dout));
    check("nop_no_req", 64'(req_valid), 64'd0);

    // Busy: second scan while first request is outstanding
    push("dmi_cap_busy0", dmi(m_last, m_resp, 2'b00));
    push("busy_read_req", dmi(6'h12, 32'h0, 2'b01));
    scan_dr(40'(dmi(6'h12, 32'h0, 2'b01)), 40, dout);
    pop_check(64'(dout));
    wait_req();
    m_last = 6'h12;
    push("dmi_cap_busy1", dmi(m_last, m_resp, 2'b00));
    scan_dr(40'(dmi(6'h13, 32'hDEADBEEF, 2'b10)), 40, dout);
    pop_check(64'(dout));
    check("busy_valid_held", 64'(req_valid), 64'd1);
    check("busy_data_held", 64'(req_data), dmi(6'h12, 32'h0, 2'b01));
    push("dmi_cap_busy_status", dmi(m_last, m_resp, ERR));
    scan_dr('0, 40, dout);
    pop_check(64'(dout));
    scan_ir(5'h10, irc);
    push("dtmcs_dmistat_err", 64'h5061 | (64'(ERR) << 10));
    scan_dr('0, 32, dout);
    pop_check(64'(dout));
    push("dtmcs_dmireset_cap", 64'h5061 | (64'(ERR) << 10));
    scan_dr(40'h0_0001_0000, 32, dout);
    pop_check(64'(dout));
    push("dtmcs_after_dmireset", 64'h5061);
    scan_dr('0, 32, dout);
    pop_check(64'(dout));
    dm_complete(6'h12, 32'h11111111);
    m_resp = 32'h11111111;

    // TLR mid Shift-DR with a pending request
    scan_ir(5'h11, irc);
    push("dmi_cap_pre_tlr", dmi(m_last, m_resp, 2'b00));
    push("tlr_read_req", dmi(6'h14, 32'h0, 2'b01));
    scan_dr(40'(dmi(6'h14, 32'h0, 2'b01)), 40, dout);
    pop_check(64'(dout));
    wait_req();
    m_last = 6'h14;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, t);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    check("tlr_valid_kept", 64'(req_valid), 64'd1);
    check("tlr_data_kept", 64'(req_data), dmi(6'h14, 32'h0, 2'b01));
    push("idcode_after_tlr", 64'h1E200A6D);
    scan_dr('0, 32, dout);
    pop_check(64'(dout));
    dm_complete(6'h14, 32'h22222222);
    m_resp = 32'h22222222;

    // Reset in the middle of a request/response
    scan_ir(5'h10, irc);
    push("dtmcs_after_tlr_update", 64'h5061 | (64'(ERR) << 10));
    scan_dr(40'h0_0001_0000, 32, dout);
    pop_check(64'(dout));
    scan_ir(5'h11, irc);
    push("dmi_cap_pre_rst", dmi(m_last, m_resp, 2'b00));
    push("rst_write_req", dmi(6'h15, 32'h5A5A5A5A, 2'b10));
    scan_dr(40'(dmi(6'h15, 32'h5A5A5A5A, 2'b10)), 40, dout);
    pop_check(64'(dout));
    wait_req();
    @(negedge clk);
    resp_valid = 1'b1;
    resp_data  = {6'h15, 32'h33333333, 2'b00};
    @(negedge clk);
    check("pre_rst_ack", 64'(dtm_ack), 64'd1);
    tck = 1'b0;
    rst_n = 1'b0;
    #1ns;
    check("rst_valid_ack", 64'({req_valid, dtm_ack}), 64'd0);
    check("rst_req_data", 64'(req_data), 64'd0);
    resp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0, t);
    push("idcode_after_rst", 64'h1E200A6D);
    scan_dr('0, 32, dout);
    pop_check(64'(dout));
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
